sram_pin_host: RTL and testbench
================================

SRAM_PIN_HOST -- requirements
Module: sram_pin_host

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, SRAM word-address width carried on pin_uio[5:0].
REQ-002 SHALL have parameter DATA_W, default 8, data width on pin_ui and pin_uo.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from strobe to valid pin_uo read data; legal range 1..7.
REQ-004 SHALL have parameter WR_REC, default 1, idle cycles after a write strobe before the next request is accepted; legal range 0..7.
REQ-005 SHALL have ports, in this order:
  clk  input  1  single clock, rising edge.
  rst  input  1  asynchronous, active-high reset.
  req_valid  input  1  request offered.
  req_ready  output  1  request accepted when valid&ready.
  req_we  input  1  1=write, 0=read.
  req_addr  input  ADDR_W  word address.
  req_wdata  input  DATA_W  write data.
  rsp_valid  output  1  read data available.
  rsp_ready  input  1  consumer takes read data.
  rsp_rdata  output  DATA_W  captured read data.
  pin_ui  output  8  drives DUT ui_in (write data).
  pin_uio  output  8  drives DUT uio_in: [7]=strobe, [6]=we, [5:0]=addr.
  pin_uo  input  8  DUT uo_out (read data).
  pin_uio_oe  input  8  DUT uio_oe; must be 0 (all uio are DUT inputs).
  busy  output  1  FSM not in IDLE.
  err_oe  output  1  sticky protocol error flag.

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, RD_WAIT, RSP, WR_REC; encoding in shared package.
REQ-007 req_ready SHALL be 1 only in IDLE; one transaction outstanding at a time.
REQ-008 On accept, req_we/addr/wdata SHALL be registered; next cycle FSM enters ISSUE.
REQ-009 In ISSUE, pin_uio[7] SHALL be 1 for exactly one cycle with pin_uio[6:0]/pin_ui from the registered request; in all other states pin_uio[7]=0.
REQ-010 pin_ui and pin_uio[6:0] SHALL hold their last issued values outside ISSUE (no glitching to 0).
REQ-011 Read: ISSUE -> RD_WAIT; a down-counter loaded with RD_LAT-1 counts in RD_WAIT; at counter 0 pin_uo SHALL be captured into rsp_rdata and FSM SHALL go to RSP.
REQ-012 With RD_LAT=2: strobe at cycle N, pin_uo sampled at rising edge ending cycle N+2, rsp_valid high from cycle N+3.
REQ-013 RSP: rsp_valid=1, rsp_rdata stable; on rsp_ready=1 return to IDLE next cycle; no timeout, backpressure unbounded.
REQ-014 Write: ISSUE -> WR_REC if WR_REC>0, counting WR_REC cycles, else ISSUE -> IDLE directly; writes produce no response.
REQ-015 rsp_valid SHALL be 0 in every state except RSP.
REQ-016 err_oe SHALL set when pin_uio_oe != 0 in any cycle that pin_uio[7]=1, and clear only on reset.
REQ-017 err_oe SHALL NOT block operation; transactions complete normally.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 req_addr wider than 6 bits is illegal; upper pin_uio bits are fixed as above.

Reset
REQ-020 rst SHALL asynchronously force: state IDLE, req_ready 1 after release, rsp_valid 0, rsp_rdata 0, pin_ui 0, pin_uio 0, busy 0, err_oe 0, counters 0.
REQ-021 Reset asserted mid-transaction SHALL abort it with no response and strobe deasserted immediately.

Structure
REQ-022 Package sram_pin_pkg SHALL hold the state enum, pin-bit positions (STROBE_BIT=7, WE_BIT=6, ADDR_LSB=0) and default parameter constants.
REQ-023 One sub-module, sram_pin_cnt (loadable 3-bit down-counter with zero flag), SHALL be shared by RD_WAIT and WR_REC.

Verification
REQ-024 Write 0xA5 to addr 0x12 -> one-cycle pin_uio=0xD2, pin_ui=0xA5; req_ready back after WR_REC+1 cycles.
REQ-025 Read addr 0x12 with model returning 0xA5 at RD_LAT=2 -> rsp_rdata=0xA5, rsp_valid in cycle N+3.
REQ-026 Read with rsp_ready held low 10 cycles -> rsp_valid and data stable, req_ready=0 throughout.
REQ-027 pin_uio_oe=0x01 during a strobe -> err_oe=1 and stays set; transaction still completes.
REQ-028 rst pulsed during RD_WAIT -> all outputs at reset values, no rsp_valid afterward.
REQ-029 Back-to-back writes to addr 0x00 and 0x3F with WR_REC=0 -> strobes two cycles apart, addresses wrap correctly in 6 bits.

Source files
------------

// File: rtl/sram_pin_pkg.sv
// Shared definitions for the SRAM pin-level host: FSM encoding, pin-bit
// positions on the uio bus and default parameter values.
package sram_pin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RSP     = 3'd3,
    ST_WR_REC  = 3'd4
  } state_t;

  localparam int STROBE_BIT = 7;
  localparam int WE_BIT     = 6;
  localparam int ADDR_LSB   = 0;
  localparam int PIN_ADDR_W = 6;

  localparam int CNT_W = 3;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 2;
  localparam int DEF_WR_REC = 1;

endpackage

// File: rtl/sram_pin_cnt.sv
// Loadable down-counter with zero flag; shared by the read-latency wait and
// the write-recovery wait since only one of them is ever running.
module sram_pin_cnt
  import sram_pin_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_pin_host.sv
// Pin-level host that drives an SRAM-style DUT through ui/uio/uo pins:
// one request at a time, a single-cycle strobe, fixed read latency and
// optional write recovery.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | ready for a request
//   ST_ISSUE   | strobe high for one cycle with the registered request
//   ST_RD_WAIT | counting down read latency; capture uo at zero
//   ST_RSP     | read data held on rsp_* until consumer takes it
//   ST_WR_REC  | counting down write recovery before going idle
module sram_pin_host
  import sram_pin_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int WR_REC = DEF_WR_REC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        pin_ui,
  output logic [7:0]        pin_uio,
  input  logic [7:0]        pin_uo,
  input  logic [7:0]        pin_uio_oe,
  output logic              busy,
  output logic              err_oe
);

  // Counter preload: it reaches zero in the last wait cycle, so load N-1.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = (WR_REC > 0) ? CNT_W'(WR_REC - 1) : '0;

  state_t state, state_nxt;

  logic                  we_q;
  logic [PIN_ADDR_W-1:0] addr_q;
  logic [7:0]            ui_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  cnt_zero;
  logic                  cnt_load;
  logic                  cnt_dec;

  assign accept   = req_valid && (state == ST_IDLE);
  assign cnt_load = (state == ST_ISSUE);
  assign cnt_dec  = (state == ST_RD_WAIT) || (state == ST_WR_REC);

  sram_pin_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (we_q ? WR_LOAD : RD_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (!we_q)           state_nxt = ST_RD_WAIT;
        else if (WR_REC > 0) state_nxt = ST_WR_REC;
        else                 state_nxt = ST_IDLE;
      end
      ST_RD_WAIT: if (cnt_zero)  state_nxt = ST_RSP;
      ST_RSP:     if (rsp_ready) state_nxt = ST_IDLE;
      ST_WR_REC:  if (cnt_zero)  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Request registers double as the pin drivers so pins hold between strobes;
  // read capture and the sticky output-enable error live here too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      ui_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q   <= req_we;
        addr_q <= PIN_ADDR_W'(req_addr);
        ui_q   <= 8'(req_wdata);
      end
      if ((state == ST_RD_WAIT) && cnt_zero) begin
        rdata_q <= DATA_W'(pin_uo);
      end
      if ((state == ST_ISSUE) && (pin_uio_oe != '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Strobe decodes straight from state so reset drops it immediately.
  assign pin_uio[STROBE_BIT]                 = (state == ST_ISSUE);
  assign pin_uio[WE_BIT]                     = we_q;
  assign pin_uio[ADDR_LSB +: PIN_ADDR_W]     = addr_q;
  assign pin_ui    = ui_q;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RSP);
  assign rsp_rdata = rdata_q;
  assign err_oe    = err_q;

endmodule

// File: tb/tb_sram_pin_host.sv
// Bench for sram_pin_host: two instances (default timing, and RD_LAT=3 /
// WR_REC=0) checked every cycle against a timeline model of the protocol,
// plus directed scenarios with hand-computed expectations.
module tb_sram_pin_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [5:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic [7:0] pin_ui    [2];
  logic [7:0] pin_uio   [2];
  logic [7:0] pin_uo    [2];
  logic [7:0] pin_uio_oe[2];
  logic       busy      [2];
  logic       err_oe    [2];

  sram_pin_host u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .pin_ui(pin_ui[0]), .pin_uio(pin_uio[0]), .pin_uo(pin_uo[0]),
    .pin_uio_oe(pin_uio_oe[0]), .busy(busy[0]), .err_oe(err_oe[0])
  );

  sram_pin_host #(.RD_LAT(3), .WR_REC(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .pin_ui(pin_ui[1]), .pin_uio(pin_uio[1]), .pin_uo(pin_uo[1]),
    .pin_uio_oe(pin_uio_oe[1]), .busy(busy[1]), .err_oe(err_oe[1])
  );

  function automatic int rdl(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int wrr(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Model: a transaction is described by its strobe cycle; everything else
  // follows from cycle arithmetic relative to it.
  bit         m_idle [2];
  int         m_issue[2];
  bit         m_we   [2];
  logic [5:0] m_addr [2];
  logic [7:0] m_wdata[2];
  logic [7:0] m_rdata[2];
  bit         m_err  [2];
  logic [7:0] mem    [2][64];

  int cyc;
  int n_cmp;
  int n_bad;

  function automatic void chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL u%0d.%s: got %02h expected %02h (cycle %0d)", i, nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i]  = 1'b1;
      m_issue[i] = -100;
      m_we[i]    = 1'b0;
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_rdata[i] = '0;
      m_err[i]   = 1'b0;
    end
  endfunction

  function automatic void compare(int i);
    bit strobe;
    bit rv;
    strobe = !m_idle[i] && (cyc == m_issue[i]);
    rv     = !m_idle[i] && !m_we[i] && (cyc >= m_issue[i] + rdl(i) + 1);
    chk("req_ready", i, 8'(req_ready[i]), 8'(m_idle[i]));
    chk("busy",      i, 8'(busy[i]),      8'(!m_idle[i]));
    chk("rsp_valid", i, 8'(rsp_valid[i]), 8'(rv));
    chk("rsp_rdata", i, rsp_rdata[i],     m_rdata[i]);
    chk("pin_ui",    i, pin_ui[i],        m_wdata[i]);
    chk("pin_uio",   i, pin_uio[i],       {strobe, m_we[i], m_addr[i]});
    chk("err_oe",    i, 8'(err_oe[i]),    8'(m_err[i]));
  endfunction

  // External SRAM: valid data only in the sampling cycle, inverted otherwise.
  function automatic void sram_drive(int i);
    if (!m_idle[i] && !m_we[i] && (cyc == m_issue[i] + rdl(i)))
      pin_uo[i] = mem[i][m_addr[i]];
    else
      pin_uo[i] = ~mem[i][m_addr[i]];
  endfunction

  function automatic void model_update(int i);
    if (rst) begin
      m_idle[i]  = 1'b1;
      m_issue[i] = -100;
      m_we[i]    = 1'b0;
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_rdata[i] = '0;
      m_err[i]   = 1'b0;
    end else if (m_idle[i]) begin
      if (req_valid[i]) begin
        m_idle[i]  = 1'b0;
        m_issue[i] = cyc + 1;
        m_we[i]    = req_we[i];
        m_addr[i]  = req_addr[i];
        m_wdata[i] = req_wdata[i];
      end
    end else begin
      if (cyc == m_issue[i]) begin
        if (pin_uio_oe[i] != 8'h00) m_err[i] = 1'b1;
        if (m_we[i]) mem[i][m_addr[i]] = m_wdata[i];
      end
      if (m_we[i]) begin
        if (cyc == m_issue[i] + wrr(i)) m_idle[i] = 1'b1;
      end else begin
        if (cyc == m_issue[i] + rdl(i)) m_rdata[i] = pin_uo[i];
        if ((cyc >= m_issue[i] + rdl(i) + 1) && rsp_ready[i]) m_idle[i] = 1'b1;
      end
    end
  endfunction

  // One clock: compare and drive the SRAM on the falling edge, advance the
  // model just after the rising edge; callers change inputs after return.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      compare(i);
      sram_drive(i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_update(i);
    cyc++;
  endtask

  task automatic wait_ready(input int i, output int k);
    k = 0;
    while ((req_ready[i] !== 1'b1) && (k < 64)) begin
      step();
      k++;
    end
    if (k >= 64) chk("ready_timeout", i, 8'(req_ready[i]), 8'h01);
  endtask

  task automatic wait_rsp(input int i, output int k);
    k = 0;
    while ((rsp_valid[i] !== 1'b1) && (k < 64)) begin
      step();
      k++;
    end
    if (k >= 64) chk("rsp_timeout", i, 8'(rsp_valid[i]), 8'h01);
  endtask

  // Returns in the strobe cycle of the new transaction.
  task automatic issue(input int i, input bit we, input logic [5:0] a, input logic [7:0] d);
    int k;
    wait_ready(i, k);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    step();
    req_valid[i] = 1'b0;
  endtask

  task automatic random_phase(input int n, input bit allow_oe);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = 1'($urandom_range(0, 1));
        req_we[i]    = 1'($urandom_range(0, 1));
        req_addr[i]  = 6'($urandom);
        req_wdata[i] = 8'($urandom);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
        pin_uio_oe[i] = (allow_oe && ($urandom_range(0, 31) == 0)) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      rsp_ready[i]  = 1'b1;
      pin_uio_oe[i] = 8'h00;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int s1;
    rst   = 1'b1;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      rsp_ready[i]  = 1'b1;
      pin_uio_oe[i] = 8'h00;
      pin_uo[i]     = 8'h00;
      for (int a = 0; a < 64; a++) mem[i][a] = 8'($urandom);
    end
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset values
    chk("rst_ready", 0, 8'(req_ready[0]), 8'h01);
    chk("rst_busy",  0, 8'(busy[0]),      8'h00);
    chk("rst_uio",   0, pin_uio[0],       8'h00);
    chk("rst_ui",    0, pin_ui[0],        8'h00);
    chk("rst_rdata", 0, rsp_rdata[0],     8'h00);

    random_phase(500, 1'b0);
    wait_ready(0, k);
    wait_ready(1, k);

    // Write 0xA5 to 0x12
    issue(0, 1'b1, 6'h12, 8'hA5);
    chk("wr_uio", 0, pin_uio[0], 8'hD2);
    chk("wr_ui",  0, pin_ui[0],  8'hA5);
    wait_ready(0, k);
    chk("wr_recovery", 0, 8'(k), 8'd2);
    step();
    chk("wr_hold_uio", 0, pin_uio[0], 8'h52);

    // Read 0x12 back: rsp_valid three cycles after the strobe
    rsp_ready[0] = 1'b1;
    issue(0, 1'b0, 6'h12, 8'h00);
    chk("rd_uio", 0, pin_uio[0], 8'h92);
    wait_rsp(0, k);
    chk("rd_latency", 0, 8'(k),        8'd3);
    chk("rd_data",    0, rsp_rdata[0], 8'hA5);
    wait_ready(0, k);

    // Response backpressure for 10 cycles
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 6'h12, 8'h00);
    wait_rsp(0, k);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 0, 8'(rsp_valid[0]), 8'h01);
      chk("bp_data",  0, rsp_rdata[0],     8'hA5);
      chk("bp_ready", 0, 8'(req_ready[0]), 8'h00);
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    chk("bp_release", 0, 8'(req_ready[0]), 8'h01);

    // Output-enable fault during a strobe
    pin_uio_oe[0] = 8'h01;
    issue(0, 1'b1, 6'h05, 8'h3C);
    wait_ready(0, k);
    chk("oe_completes", 0, 8'(k), 8'd2);
    pin_uio_oe[0] = 8'h00;
    chk("oe_err_set", 0, 8'(err_oe[0]), 8'h01);
    repeat (5) step();
    chk("oe_err_sticky", 0, 8'(err_oe[0]), 8'h01);

    // Reset in the middle of a read
    issue(0, 1'b0, 6'h05, 8'h00);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 0, 8'(rsp_valid[0]), 8'h00);
    chk("mid_rst_busy",  0, 8'(busy[0]),      8'h00);
    chk("mid_rst_uio",   0, pin_uio[0],       8'h00);
    chk("mid_rst_ui",    0, pin_ui[0],        8'h00);
    chk("mid_rst_rdata", 0, rsp_rdata[0],     8'h00);
    chk("mid_rst_err",   0, 8'(err_oe[0]),    8'h00);
    model_reset();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("post_rst_valid", 0, 8'(rsp_valid[0]), 8'h00);
    end
    chk("post_rst_ready", 0, 8'(req_ready[0]), 8'h01);

    // Back-to-back writes at WR_REC=0: 0x00 then 0x3F, strobes 2 apart
    rsp_ready[1] = 1'b1;
    wait_ready(1, k);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 6'h00;
    req_wdata[1] = 8'h11;
    step();
    chk("b2b_uio0", 1, pin_uio[1], 8'hC0);
    s1 = cyc;
    req_addr[1]  = 6'h3F;
    req_wdata[1] = 8'h22;
    k = 0;
    do begin
      step();
      k++;
    end while ((pin_uio[1][7] !== 1'b1) && (k < 16));
    req_valid[1] = 1'b0;
    chk("b2b_spacing", 1, 8'(cyc - s1), 8'd2);
    chk("b2b_uio1",    1, pin_uio[1],   8'hFF);
    chk("b2b_ui1",     1, pin_ui[1],    8'h22);
    wait_ready(1, k);

    random_phase(600, 1'b1);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
